// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   localparam int unsigned DefaultWidth = 16;
   localparam int unsigned GroupSize    = 4;

endpackage

// File: rtl/seq_divider_borrow_lookahead.sv
// 4-bit borrow-lookahead group: borrows into each bit and the group borrow-out.
module seq_divider_borrow_lookahead (
   input  logic       bin,
   input  logic [3:0] p,
   input  logic [3:0] g,
   output logic [3:0] b,
   output logic       bout
);

   always_comb begin
      b[0] = bin;
      b[1] = g[0] | (p[0] & bin);
      b[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bin);
      b[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bin);
      bout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & bin);
   end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle, with a
// borrow-lookahead trial subtractor.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   // Subtractor spans WIDTH+1 bits rounded up to whole groups.
   localparam int unsigned NumGroups = (WIDTH + GroupSize) / GroupSize;
   localparam int unsigned PadWidth  = NumGroups * GroupSize;
   localparam int unsigned CntWidth  = $clog2(WIDTH + 1);

   state_e                state_q, state_d;
   logic [WIDTH:0]        r_q, r_d;
   logic [WIDTH-1:0]      q_q, q_d;
   logic [WIDTH-1:0]      dvs_q, dvs_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]      quotient_q, quotient_d;
   logic [WIDTH-1:0]      remainder_q, remainder_d;
   logic                  dbz_q, dbz_d;

   logic [WIDTH:0]        r_shift;
   logic [PadWidth-1:0]   a_pad, d_pad, p_pad, g_pad, b_pad;
   logic [NumGroups:0]    bchain;
   logic [WIDTH:0]        diff;
   logic                  no_borrow;
   logic                  unused_bits;

   assign r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign a_pad   = {{(PadWidth-WIDTH-1){1'b0}}, r_shift};
   assign d_pad   = {{(PadWidth-WIDTH){1'b0}}, dvs_q};
   assign p_pad   = ~(a_pad ^ d_pad);
   assign g_pad   = ~a_pad & d_pad;
   assign bchain[0] = 1'b0;

   for (genvar i = 0; i < NumGroups; i++) begin : g_group
      seq_divider_borrow_lookahead u_bla (
         .bin  (bchain[i]),
         .p    (p_pad[GroupSize*i +: GroupSize]),
         .g    (g_pad[GroupSize*i +: GroupSize]),
         .b    (b_pad[GroupSize*i +: GroupSize]),
         .bout (bchain[i+1])
      );
   end

   assign diff      = ~p_pad[WIDTH:0] ^ b_pad[WIDTH:0];
   assign no_borrow = ~bchain[NumGroups];
   // R never exceeds the divisor, so its top bit and the pad borrows carry no information.
   assign unused_bits = ^{r_q[WIDTH], b_pad[PadWidth-1:WIDTH+1]};

   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      q_d         = q_q;
      dvs_d       = dvs_q;
      cnt_d       = cnt_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      dbz_d       = dbz_q;
      unique case (state_q)
         StRun: begin
            r_d   = no_borrow ? diff : r_shift;
            q_d   = {q_q[WIDTH-2:0], no_borrow};
            cnt_d = cnt_q - CntWidth'(1);
            if (cnt_q == CntWidth'(1)) begin
               state_d     = StDone;
               quotient_d  = q_d;
               remainder_d = r_d[WIDTH-1:0];
               dbz_d       = 1'b0;
            end
         end
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               r_d   = '0;
               q_d   = dividend;
               dvs_d = divisor;
               cnt_d = CntWidth'(WIDTH);
               if (divisor == '0) begin
                  state_d     = StDone;
                  quotient_d  = '1;
                  remainder_d = dividend;
                  dbz_d       = 1'b1;
               end else begin
                  state_d = StRun;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         r_q         <= '0;
         q_q         <= '0;
         dvs_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         dbz_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         q_q         <= q_d;
         dvs_q       <= dvs_d;
         cnt_q       <= cnt_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
         dbz_q       <= dbz_d;
      end
   end

   assign busy        = (state_q == StRun);
   assign done        = (state_q == StDone);
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the calculator datapath. It is the inverse-direction companion to the carry-lookahead adder path: each iteration performs a trial subtraction through a 4-bit-group borrow-lookahead network. It accepts a dividend/divisor pair on a start strobe and produces one quotient bit per cycle. It then reports quotient, remainder and divide-by-zero with a one-cycle done pulse.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- dividend  in  WIDTH  unsigned dividend; captured in the start cycle.
- divisor  in  WIDTH  unsigned divisor; captured in the start cycle.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse when results become valid.
- quotient  out  WIDTH  unsigned quotient; held until next accepted start.
- remainder  out  WIDTH  unsigned remainder; held until next accepted start.
- div_by_zero  out  1  set with done when the captured divisor was 0; held with results.

## Operation
- States:
  - IDLE: wait for start.
  - RUN: iterate.
  - DONE: one cycle, done=1.
- IDLE or DONE with start=1:
  - Capture the operands.
  - Clear the partial remainder R (WIDTH+1 bits).
  - Load the quotient shift register with dividend.
  - Set the iteration counter to WIDTH.
  - If divisor=0, go to DONE. Otherwise go to RUN.
- RUN, each cycle:
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}, then shift Q left by one.
  - Trial difference T = R' - divisor, computed by the borrow-lookahead subtractor.
  - If there is no borrow out: R = T and the new Q LSB = 1.
  - Otherwise: R = R' and the new Q LSB = 0.
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE: outputs valid, done=1. Next state is IDLE, unless start=1, in which case the new operation is accepted as described above.
- Divide by zero:
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
  - No iterations are performed.
- start while busy=1 is ignored. It is not queued.
- quotient, remainder and div_by_zero change only on the cycle that enters DONE.
- Arithmetic is unsigned only. The remainder is always less than divisor when divisor is not 0.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, all internal registers 0.
- Normal division, with start accepted in cycle t:
  - busy=1 in cycles t+1 .. t+WIDTH.
  - done=1 in cycle t+WIDTH+1.
  - Total latency is WIDTH+1 cycles.
- Divide by zero, with start accepted in cycle t: busy stays 0 and done=1 in cycle t+1.
- busy and done are never high in the same cycle.
- Back-to-back operation: start in the DONE cycle is accepted, so the next done pulse follows WIDTH+1 cycles later.
- rst asserted mid-operation: on the next edge, return to IDLE and clear all outputs. No done pulse is produced for the aborted operation.
- rst has priority over start in the same cycle.

## Structure
- Shared package holds:
  - the state encoding (IDLE, RUN, DONE);
  - the default WIDTH;
  - the group size constant (4).
- One sub-module, borrow_lookahead:
  - Interface: 4-bit group, inputs bin, p[3:0], g[3:0]; outputs b[3:0], bout.
  - Propagate = ~(a ^ d). Generate = ~a & d.
  - Instantiate it (WIDTH+1)/4 rounded up times, with group borrows chained ripple-fashion.
  - Top bit handling: pad the subtractor to a multiple of 4 with zero-extended operands.
- Counter width: $clog2(WIDTH+1).

## Test plan
- WIDTH=16, 100 / 7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 17 cycles after the start cycle, busy high for 16 cycles.
- 0xFFFF / 1 -> quotient=0xFFFF, remainder=0. Also 0xFFFF / 0xFFFF -> quotient=1, remainder=0.
- 3 / 10 -> quotient=0, remainder=3. Also 0 / 5 -> quotient=0, remainder=0.
- 5 / 0 -> div_by_zero=1, quotient=0xFFFF, remainder=5, done in cycle t+1, busy never high.
- Start 1000/3, pulse start with 9/2 at cycle t+5 -> second request ignored; result is quotient=333, remainder=1. Then start 9/2 in the DONE cycle -> quotient=4, remainder=1 at 17 cycles later.
- Start 200/9, assert rst at cycle t+8 -> all outputs 0 next cycle, no done pulse. A subsequent 200/9 -> quotient=22, remainder=2.
